// File: rtl/mem_wb.sv
// ---------------------------------------------------------------------------
// mem_wb : MEM -> WB pipeline register of the 5-stage MIPS core.
//
// Takes the MEM-stage results (GPR write, HI/LO write, LLbit update) and
// presents them one cycle later to the register file, the HI/LO unit and the
// LLbit register. It obeys the pipeline stall/flush controls and counts
// retired instructions.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   stall_mem      MEM stage stalled this cycle
//   stall_wb       WB stage stalled this cycle
//   flush          exception/eret flush; kills the entry being captured
//   mem_valid      MEM stage holds a real instruction (0 = bubble)
//   mem_wreg       GPR write enable
//   mem_waddr      GPR destination address
//   mem_wdata      GPR write data
//   mem_whilo      HI/LO write enable
//   mem_hi         HI write value
//   mem_lo         LO write value
//   mem_llbit_we   LLbit write enable
//   mem_llbit_val  LLbit value
//   wb_*           registered copies of the above, as seen by WB
//   retired_cnt    count of valid instructions captured into WB (wraps)
//
// All outputs are driven straight from registers. There is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module mem_wb #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_mem,
  input  logic             stall_wb,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_wreg,
  input  logic [AW-1:0]    mem_waddr,
  input  logic [DW-1:0]    mem_wdata,
  input  logic             mem_whilo,
  input  logic [DW-1:0]    mem_hi,
  input  logic [DW-1:0]    mem_lo,
  input  logic             mem_llbit_we,
  input  logic             mem_llbit_val,
  output logic             wb_valid,
  output logic             wb_wreg,
  output logic [AW-1:0]    wb_waddr,
  output logic [DW-1:0]    wb_wdata,
  output logic             wb_whilo,
  output logic [DW-1:0]    wb_hi,
  output logic [DW-1:0]    wb_lo,
  output logic             wb_llbit_we,
  output logic             wb_llbit_val,
  output logic [CNT_W-1:0] retired_cnt
);

  // Per-cycle load action, chosen from the stall/flush controls.
  localparam logic [1:0] ACT_CAPTURE = 2'd0;
  localparam logic [1:0] ACT_BUBBLE  = 2'd1;
  localparam logic [1:0] ACT_HOLD    = 2'd2;

  logic [1:0]       act;

  logic             valid_q,    valid_d;
  logic             wreg_q,     wreg_d;
  logic [AW-1:0]    waddr_q,    waddr_d;
  logic [DW-1:0]    wdata_q,    wdata_d;
  logic             whilo_q,    whilo_d;
  logic [DW-1:0]    hi_q,       hi_d;
  logic [DW-1:0]    lo_q,       lo_d;
  logic             llbit_we_q, llbit_we_d;
  logic             llbit_val_q, llbit_val_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  // Flush beats both stalls. A MEM stall with WB running has to insert a
  // bubble, because MEM will present the same entry again next cycle and WB
  // must not execute it twice. The illegal case (WB stalled, MEM running)
  // falls through to a normal capture.
  always_comb begin
    act = ACT_CAPTURE;
    if (flush) begin
      act = ACT_BUBBLE;
    end else if (stall_mem && !stall_wb) begin
      act = ACT_BUBBLE;
    end else if (stall_mem && stall_wb) begin
      act = ACT_HOLD;
    end
  end

  always_comb begin
    valid_d       = valid_q;
    wreg_d        = wreg_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    whilo_d       = whilo_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    llbit_we_d    = llbit_we_q;
    llbit_val_d   = llbit_val_q;
    retired_cnt_d = retired_cnt_q;

    case (act)
      ACT_BUBBLE: begin
        // The counter is not part of the bubble and keeps its value.
        valid_d     = 1'b0;
        wreg_d      = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        whilo_d     = 1'b0;
        hi_d        = '0;
        lo_d        = '0;
        llbit_we_d  = 1'b0;
        llbit_val_d = 1'b0;
      end
      ACT_CAPTURE: begin
        // A bubble arriving from MEM may still carry stale enables. Mask
        // them here so nothing is written. Data fields pass through as
        // presented.
        valid_d     = mem_valid;
        wreg_d      = mem_wreg     & mem_valid;
        waddr_d     = mem_waddr;
        wdata_d     = mem_wdata;
        whilo_d     = mem_whilo    & mem_valid;
        hi_d        = mem_hi;
        lo_d        = mem_lo;
        llbit_we_d  = mem_llbit_we & mem_valid;
        llbit_val_d = mem_llbit_val;
        if (mem_valid) begin
          retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // ACT_HOLD: keep every register as it is.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      wreg_q        <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      whilo_q       <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      llbit_we_q    <= 1'b0;
      llbit_val_q   <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      wreg_q        <= wreg_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      whilo_q       <= whilo_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      llbit_we_q    <= llbit_we_d;
      llbit_val_q   <= llbit_val_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign wb_valid     = valid_q;
  assign wb_wreg      = wreg_q;
  assign wb_waddr     = waddr_q;
  assign wb_wdata     = wdata_q;
  assign wb_whilo     = whilo_q;
  assign wb_hi        = hi_q;
  assign wb_lo        = lo_q;
  assign wb_llbit_we  = llbit_we_q;
  assign wb_llbit_val = llbit_val_q;
  assign retired_cnt  = retired_cnt_q;

endmodule
